// File: rtl/heater_pkg.sv
// heater_pkg: shared definitions for the heater bank controller.
//   heater_mode_e : operating mode decoded from sw[7:6]
//   clog2         : ceiling log2 for elaboration-time sizing
//   DEF_*         : default parameter values
package heater_pkg;

  typedef enum logic [1:0] {
    HM_OFF    = 2'b00,
    HM_STATIC = 2'b01,
    HM_PWM    = 2'b10,
    HM_SWEEP  = 2'b11
  } heater_mode_e;

  localparam int DEF_WIDTH       = 32;
  localparam int DEF_N_BANK      = 8;
  localparam int DEF_PWM_BITS    = 6;
  localparam int DEF_STEP_CYCLES = 1024;

  // Smallest r with 2**r >= v. It only runs at elaboration.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/heater_ramp.sv
// heater_ramp: moves the active bank count one step toward a target.
//   clk, rst    : clock, asynchronous active-high reset
//   target      : desired bank count T
//   force_zero  : kills the count to 0 immediately, bypassing the ramp
//   count       : active bank count A
//   tick        : high on the last cycle of each STEP_CYCLES interval
module heater_ramp
  import heater_pkg::*;
#(
  parameter int N_BANK      = DEF_N_BANK,
  parameter int STEP_CYCLES = DEF_STEP_CYCLES,
  parameter int AW          = clog2(DEF_N_BANK) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] target,
  input  logic          force_zero,
  output logic [AW-1:0] count,
  output logic          tick
);

  localparam int SCW = clog2(STEP_CYCLES);

  logic [SCW-1:0] step_cnt;

  assign tick = (step_cnt == SCW'(STEP_CYCLES - 1));

  // The step counter runs free from reset and is never restarted, so a
  // mode change does not disturb the tick cadence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_cnt <= '0;
    end else if (tick) begin
      step_cnt <= '0;
    end else begin
      step_cnt <= step_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (force_zero) begin
      count <= '0;
    end else if (tick) begin
      if (count < target) begin
        count <= count + 1'b1;
      end else if (count > target) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/heater_bank_ctrl.sv
// heater_bank_ctrl: converts board switches into banked heater enables.
//   clk, rst  : clock, asynchronous active-high reset
//   sw[7:0]   : asynchronous switches; [7:6] mode, [PWM_BITS-1:0] level L
//   enable    : registered heater enables, bank b drives [b*BW +: BW]
//   ld[7:0]   : registered bank-on status (ungated by PWM)
//   at_target : registered, high when active count equals target
module heater_bank_ctrl
  import heater_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int N_BANK      = DEF_N_BANK,
  parameter int PWM_BITS    = DEF_PWM_BITS,
  parameter int STEP_CYCLES = DEF_STEP_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       sw,
  output logic [WIDTH-1:0] enable,
  output logic [7:0]       ld,
  output logic             at_target
);

  localparam int AW = clog2(N_BANK) + 1;
  localparam int BW = WIDTH / N_BANK;
  localparam int PW = PWM_BITS + AW + 1;

  logic [7:0]          s1, s2;
  heater_mode_e        mode;
  logic [PWM_BITS-1:0] lvl;
  logic [PW-1:0]       prod;
  logic [AW-1:0]       tgt, cnt;
  logic                tick;
  logic                dir_up;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                pwm_on;
  logic [N_BANK-1:0]   bank_on;
  logic [WIDTH-1:0]    enable_nxt;
  logic [7:0]          ld_nxt;

  // Two-flop synchronizer; everything downstream decodes s2 only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sw;
      s2 <= s1;
    end
  end

  assign mode = heater_mode_e'(s2[7:6]);

  // Level is the low switch bits, zero-extended when the field is wider
  // than the six switches available.
  always_comb begin
    lvl = '0;
    for (int i = 0; i < PWM_BITS; i++) begin
      if (i < 6) lvl[i] = s2[i];
    end
  end

  // ceil(L * N_BANK / 2^PWM_BITS); N_BANK is a power of two so this is a
  // rounded-up shift.
  assign prod = PW'(lvl) * PW'(N_BANK) + PW'((1 << PWM_BITS) - 1);

  always_comb begin
    tgt = '0;
    unique case (mode)
      HM_OFF:    tgt = '0;
      HM_STATIC: tgt = AW'(prod >> PWM_BITS);
      HM_PWM:    tgt = AW'(N_BANK);
      HM_SWEEP:  tgt = dir_up ? AW'(N_BANK) : '0;
      default:   tgt = '0;
    endcase
  end

  heater_ramp #(
    .N_BANK      (N_BANK),
    .STEP_CYCLES (STEP_CYCLES),
    .AW          (AW)
  ) u_ramp (
    .clk        (clk),
    .rst        (rst),
    .target     (tgt),
    .force_zero (mode == HM_OFF),
    .count      (cnt),
    .tick       (tick)
  );

  // Sweep direction. Held up outside SWEEP so every entry starts upward;
  // it turns at the extremes of the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_up <= 1'b1;
    end else if (mode != HM_SWEEP) begin
      dir_up <= 1'b1;
    end else if (cnt == AW'(N_BANK)) begin
      dir_up <= 1'b0;
    end else if (cnt == '0) begin
      dir_up <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  assign pwm_on = (pwm_cnt < lvl);

  always_comb begin
    bank_on    = '0;
    enable_nxt = '0;
    ld_nxt     = '0;
    for (int b = 0; b < N_BANK; b++) begin
      bank_on[b] = (AW'(b) < cnt);
      if (mode != HM_OFF) begin
        enable_nxt[b*BW +: BW] = {BW{bank_on[b] & ((mode != HM_PWM) | pwm_on)}};
      end
    end
    for (int i = 0; i < 8; i++) begin
      if (i < N_BANK) ld_nxt[i] = bank_on[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable    <= '0;
      ld        <= '0;
      at_target <= 1'b0;
    end else begin
      enable    <= enable_nxt;
      ld        <= ld_nxt;
      at_target <= (cnt == tgt);
    end
  end

endmodule
